eda_visited_map: RTL and testbench

//  Per-pixel visited bitmap for the regional-max flood engine. Successor to the fixed 8-neighbour iterated RAM:
//  NUM_PORTS mark/lookup ports, single posedge clock, same-cycle write bypass, visited-pixel counter.

---
 rtl/eda_visited_map.sv | 211 +++++++++++++++++++++
 tb/tb_eda_visited_map.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eda_visited_map.sv
// Per-pixel visited bitmap: multi-port mark/lookup with same-cycle bypass,
// visited counter, next-unvisited raster scan and row-sweep clear.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 3
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH (`CFG_I_WIDTH + `CFG_J_WIDTH)
`endif

module eda_visited_map #(
    parameter int M          = `CFG_M,
    parameter int N          = `CFG_N,
    parameter int I_WIDTH    = `CFG_I_WIDTH,
    parameter int J_WIDTH    = `CFG_J_WIDTH,
    parameter int ADDR_WIDTH = `CFG_ADDR_WIDTH,
    parameter int NUM_PORTS  = 8,
    parameter int CNT_WIDTH  = $clog2(M*N+1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear_start,
    output logic                            clear_busy,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS-1:0]            port_valid,
    input  logic [NUM_PORTS-1:0]            port_mark,
    output logic [NUM_PORTS-1:0]            port_visited,
    input  logic                            scan_req,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [I_WIDTH-1:0]              rsp_row,
    output logic [J_WIDTH-1:0]              rsp_col,
    output logic                            rsp_all_done,
    output logic [CNT_WIDTH-1:0]            visited_count,
    output logic                            all_visited
);
    typedef enum logic [1:0] {IDLE, SEARCH, FOUND, CLEAR} state_t;
    localparam int SR_W = I_WIDTH + 1;

    state_t               state, state_n;
    logic [SR_W-1:0]      scan_row, scan_row_n;
    logic [I_WIDTH-1:0]   row_ptr, row_ptr_n;
    logic [I_WIDTH-1:0]   rsp_row_n;
    logic [J_WIDTH-1:0]   rsp_col_n;
    logic                 done_n;
    logic [M-1:0][N-1:0]  bitmap, set_mask;
    logic [CNT_WIDTH-1:0] new_cnt;
    logic [I_WIDTH-1:0]   pi [NUM_PORTS];
    logic [J_WIDTH-1:0]   pj [NUM_PORTS];
    logic                 clearing;
    logic [N-1:0]         row_eff;
    logic                 row_free;
    logic [J_WIDTH-1:0]   free_col;
    logic                 held_mark;

    assign clearing      = (state == CLEAR);
    assign clear_busy    = clearing;
    assign rsp_valid     = (state == FOUND);
    assign all_visited   = (visited_count == CNT_WIDTH'(M*N));

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            pi[k] = port_addr[k*ADDR_WIDTH+J_WIDTH +: I_WIDTH];
            pj[k] = port_addr[k*ADDR_WIDTH +: J_WIDTH];
        end
    end

    // Out-of-range addresses never match a cell, so they mark and hit nothing.
    always_comb begin
        set_mask = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    if (port_mark[k] && !clearing &&
                        int'(pi[k]) == r && int'(pj[k]) == c)
                        set_mask[r][c] = 1'b1;
    end

    always_comb begin
        port_visited = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    if (port_valid[k] && !clearing &&
                        int'(pi[k]) == r && int'(pj[k]) == c)
                        port_visited[k] = bitmap[r][c] | set_mask[r][c];
    end

    always_comb begin
        new_cnt = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                new_cnt = new_cnt +
                          CNT_WIDTH'(set_mask[r][c] & ~bitmap[r][c]);
    end

    // Scanned row sees this cycle's marks so a just-marked pixel is skipped.
    always_comb begin
        row_eff   = '1;
        held_mark = 1'b0;
        free_col  = '0;
        for (int r = 0; r < M; r++)
            if (int'(scan_row) == r)
                row_eff = bitmap[r] | set_mask[r];
        row_free = ~&row_eff;
        for (int c = N-1; c >= 0; c--)
            if (!row_eff[c])
                free_col = J_WIDTH'(c);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (int'(rsp_row) == r && int'(rsp_col) == c)
                    held_mark = set_mask[r][c];
    end

    always_comb begin
        state_n    = state;
        scan_row_n = scan_row;
        row_ptr_n  = row_ptr;
        rsp_row_n  = rsp_row;
        rsp_col_n  = rsp_col;
        done_n     = rsp_all_done;
        unique case (state)
            IDLE: begin
                if (clear_start) begin
                    state_n   = CLEAR;
                    row_ptr_n = '0;
                end else if (scan_req) begin
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (clear_start) begin
                    state_n   = CLEAR;
                    row_ptr_n = '0;
                end else if (int'(scan_row) >= M) begin
                    state_n   = FOUND;
                    done_n    = 1'b1;
                    rsp_row_n = '0;
                    rsp_col_n = '0;
                end else if (row_free) begin
                    state_n   = FOUND;
                    done_n    = 1'b0;
                    rsp_row_n = scan_row[I_WIDTH-1:0];
                    rsp_col_n = free_col;
                end else begin
                    scan_row_n = scan_row + SR_W'(1);
                end
            end
            FOUND: begin
                if (clear_start) begin
                    state_n   = CLEAR;
                    row_ptr_n = '0;
                end else if (rsp_ready) begin
                    state_n = IDLE;
                end else if (!rsp_all_done && held_mark) begin
                    state_n = SEARCH;
                end
            end
            CLEAR: begin
                if (int'(row_ptr) == M-1) begin
                    state_n    = IDLE;
                    scan_row_n = '0;
                end else begin
                    row_ptr_n = row_ptr + I_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            scan_row     <= '0;
            row_ptr      <= '0;
            rsp_row      <= '0;
            rsp_col      <= '0;
            rsp_all_done <= 1'b0;
        end else begin
            state        <= state_n;
            scan_row     <= scan_row_n;
            row_ptr      <= row_ptr_n;
            rsp_row      <= rsp_row_n;
            rsp_col      <= rsp_col_n;
            rsp_all_done <= done_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitmap        <= '0;
            visited_count <= '0;
        end else if (clearing) begin
            for (int r = 0; r < M; r++)
                if (int'(row_ptr) == r)
                    bitmap[r] <= '0;
            if (state_n == IDLE)
                visited_count <= '0;
        end else begin
            bitmap        <= bitmap | set_mask;
            visited_count <= visited_count + new_cnt;
        end
    end
endmodule

// File: tb/tb_eda_visited_map.sv
// Scoreboard bench for eda_visited_map: stimulus pushes expected scan
// results, a negedge monitor pops and compares on each accepted response.
module tb_eda_visited_map;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int JW = 2;
    localparam int AW = IW + JW;
    localparam int NP = 8;
    localparam int CW = $clog2(M*N+1);

    typedef struct packed {
        logic [IW-1:0] row;
        logic [JW-1:0] col;
        logic          done;
    } rsp_t;

    logic           clk, reset_n, clear_start, clear_busy;
    logic [NP*AW-1:0] port_addr;
    logic [NP-1:0]  port_valid, port_mark, port_visited;
    logic           scan_req, rsp_valid, rsp_ready, rsp_all_done, all_visited;
    logic [IW-1:0]  rsp_row;
    logic [JW-1:0]  rsp_col;
    logic [CW-1:0]  visited_count;

    rsp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   lat, busy;

    eda_visited_map #(
        .M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW),
        .ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .port_addr(port_addr), .port_valid(port_valid),
        .port_mark(port_mark), .port_visited(port_visited),
        .scan_req(scan_req), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_row(rsp_row), .rsp_col(rsp_col), .rsp_all_done(rsp_all_done),
        .visited_count(visited_count), .all_visited(all_visited)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_done", int'(rsp_all_done), int'(e.done));
                if (!e.done) begin
                    chk("rsp_row", int'(rsp_row), int'(e.row));
                    chk("rsp_col", int'(rsp_col), int'(e.col));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        port_addr  = '0;
        port_valid = '0;
        port_mark  = '0;
    endtask

    task automatic set_port(input int k, input int i, input int j,
                            input bit v, input bit m);
        logic [IW-1:0] ii;
        logic [JW-1:0] jj;
        ii = IW'(i);
        jj = JW'(j);
        port_addr[k*AW +: AW] = {ii, jj};
        port_valid[k] = v;
        port_mark[k]  = m;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_scan(input int r, input int c, input bit d,
                           output int n);
        rsp_t e;
        e.row  = IW'(r);
        e.col  = JW'(c);
        e.done = d;
        exp_q.push_back(e);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_valid("scan", n);
        tick();
    endtask

    initial begin
        reset_n = 1'b0; clear_start = 1'b0; scan_req = 1'b0;
        rsp_ready = 1'b1;
        idle_ports();
        tick();
        tick();
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_count", int'(visited_count), 0);
        chk("rst_allv", int'(all_visited), 0);
        chk("rst_row", int'(rsp_row), 0);
        reset_n = 1'b1;
        tick();

        do_scan(0, 0, 1'b0, lat);
        chk("first_latency", lat, 2);
        chk("count_0", int'(visited_count), 0);

        set_port(0, 0, 0, 1'b0, 1'b1);
        set_port(1, 0, 1, 1'b0, 1'b1);
        set_port(2, 0, 1, 1'b0, 1'b1);
        set_port(3, 0, 1, 1'b1, 1'b1);
        set_port(4, 0, 1, 1'b1, 1'b0);
        set_port(5, 0, 2, 1'b1, 1'b0);
        #1;
        chk("bypass_p4", int'(port_visited[4]), 1);
        chk("bypass_p3", int'(port_visited[3]), 1);
        chk("unmarked_p5", int'(port_visited[5]), 0);
        chk("invalid_p0", int'(port_visited[0]), 0);
        tick();
        idle_ports();
        chk("dup_count", int'(visited_count), 2);
        set_port(0, 0, 0, 1'b1, 1'b0);
        #1;
        chk("stored_00", int'(port_visited[0]), 1);
        idle_ports();
        do_scan(0, 2, 1'b0, lat);

        set_port(0, 0, 2, 1'b0, 1'b1);
        set_port(1, 0, 3, 1'b0, 1'b1);
        set_port(2, 1, 0, 1'b0, 1'b1);
        set_port(3, 1, 1, 1'b0, 1'b1);
        tick();
        idle_ports();
        chk("count_6", int'(visited_count), 6);
        rsp_ready = 1'b0;
        exp_q.push_back('{row: IW'(1), col: JW'(3), done: 1'b0});
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_valid("hold", lat);
        chk("hold_row", int'(rsp_row), 1);
        chk("hold_col", int'(rsp_col), 2);
        tick();
        tick();
        chk("hold_stable_v", int'(rsp_valid), 1);
        chk("hold_stable_c", int'(rsp_col), 2);
        set_port(0, 1, 2, 1'b0, 1'b1);
        tick();
        idle_ports();
        chk("valid_drop", int'(rsp_valid), 0);
        wait_valid("rescan", lat);
        rsp_ready = 1'b1;
        tick();
        chk("idle_after_acc", int'(rsp_valid), 0);
        chk("count_7", int'(visited_count), 7);

        set_port(0, 1, 3, 1'b0, 1'b1);
        for (int c = 0; c < N; c++) set_port(c + 1, 2, c, 1'b0, 1'b1);
        tick();
        idle_ports();
        chk("count_12", int'(visited_count), 12);
        do_scan(3, 0, 1'b0, lat);

        for (int c = 0; c < N; c++) set_port(c, 3, c, 1'b0, 1'b1);
        tick();
        idle_ports();
        chk("count_16", int'(visited_count), 16);
        chk("all_visited", int'(all_visited), 1);
        do_scan(0, 0, 1'b1, lat);

        rsp_ready = 1'b0;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        wait_valid("found_done", lat);
        chk("found_done", int'(rsp_all_done), 1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("abort_valid", int'(rsp_valid), 0);
        busy = 0;
        scan_req = 1'b1;
        set_port(0, 0, 0, 1'b0, 1'b1);
        set_port(1, 2, 2, 1'b1, 1'b0);
        #1;
        chk("clear_lookup", int'(port_visited[1]), 0);
        while (clear_busy && busy < 20) begin
            busy++;
            tick();
        end
        scan_req = 1'b0;
        idle_ports();
        chk("clear_cycles", busy, M);
        chk("clear_count", int'(visited_count), 0);
        chk("clear_allv", int'(all_visited), 0);
        rsp_ready = 1'b1;
        tick();
        chk("scan_ignored", int'(rsp_valid), 0);
        set_port(0, 0, 0, 1'b1, 1'b0);
        #1;
        chk("mark_ignored", int'(port_visited[0]), 0);
        idle_ports();
        do_scan(0, 0, 1'b0, lat);

        set_port(0, 0, 0, 1'b0, 1'b1);
        tick();
        idle_ports();
        set_port(0, 4, 0, 1'b1, 1'b1);
        set_port(1, 4, 0, 1'b1, 1'b0);
        #1;
        chk("oor_lookup", int'(port_visited[1]), 0);
        tick();
        idle_ports();
        chk("oor_count", int'(visited_count), 1);

        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("busy_before_rst", int'(clear_busy), 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_busy2", int'(clear_busy), 0);
        chk("rst_count2", int'(visited_count), 0);
        chk("rst_valid2", int'(rsp_valid), 0);
        tick();
        chk("rst_hold_busy", int'(clear_busy), 0);
        reset_n = 1'b1;
        tick();
        set_port(0, 0, 0, 1'b1, 1'b0);
        #1;
        chk("rst_bitmap", int'(port_visited[0]), 0);
        idle_ports();
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
